// File: rtl/mem_stage.sv
// MEM pipeline stage: register-file data memory, branch resolution and MEM/WB register.
// Optional misaligned-access trapping with a saturating fault counter under MEM_MISALIGN_TRAP_EN.
module mem_stage #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        WB,
   input  logic [2:0]        M,
   input  logic [7:0]        jump_address,
   input  logic [7:0]        ALU_status,
   input  logic [31:0]       ALU_result,
   input  logic [31:0]       write_data,
   input  logic [4:0]        RegDst_address,
   output logic              PCSrc,
   output logic [7:0]        branch_target,
   output logic [1:0]        _WB,
   output logic [31:0]       _read_data,
   output logic [31:0]       _ALU_result,
   output logic [4:0]        _RegDst_address,
   output logic              mem_fault
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic [7:0]        fault_count
`endif
);

   localparam int DATA_W = 32;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] idx_p0;
   logic              branch_p0;
   logic              mem_rd_p0;
   logic              mem_wr_p0;
   logic              fault_p0;
   logic              do_store_p0;
   logic              do_load_p0;

   logic [1:0]        wb_p1;
   logic [DATA_W-1:0] rdata_p1;
   logic [DATA_W-1:0] alu_p1;
   logic [4:0]        rd_addr_p1;
   logic              fault_p1;

   // Saturating 8-bit increment used by the fault counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign branch_p0 = M[2];
   assign mem_rd_p0 = M[1];
   assign mem_wr_p0 = M[0];
   assign idx_p0    = ALU_result[ADDR_W+1:2];

   // Branch decision and target bypass the stage register entirely.
   assign PCSrc         = branch_p0 & ALU_status[0];
   assign branch_target = jump_address;

`ifdef MEM_MISALIGN_TRAP_EN
   assign fault_p0 = (mem_rd_p0 | mem_wr_p0) & (ALU_result[1:0] != 2'b00);

   logic unused_bits;
   assign unused_bits = ^{ALU_status[7:1], ALU_result[31:ADDR_W+2]};
`else
   assign fault_p0 = 1'b0;

   logic unused_bits;
   assign unused_bits = ^{ALU_status[7:1], ALU_result[31:ADDR_W+2], ALU_result[1:0]};
`endif

   // A combined read+write performs the store and returns zero as load data.
   assign do_store_p0 = mem_wr_p0 & ~fault_p0;
   assign do_load_p0  = mem_rd_p0 & ~mem_wr_p0 & ~fault_p0;

   // ---- stage boundary: data memory array ----
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_store_p0) begin
         mem[idx_p0] <= write_data;
      end
   end

   // ---- stage boundary: MEM/WB register ----
   // A store on the previous edge is already in the array, so back-to-back
   // store/load to the same index returns the new word without a bypass.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_p1      <= 2'b00;
         rdata_p1   <= '0;
         alu_p1     <= '0;
         rd_addr_p1 <= '0;
         fault_p1   <= 1'b0;
      end else begin
         wb_p1      <= fault_p0 ? 2'b00 : WB;
         rdata_p1   <= do_load_p0 ? mem[idx_p0] : '0;
         alu_p1     <= ALU_result;
         rd_addr_p1 <= RegDst_address;
         fault_p1   <= fault_p0;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic [7:0] fault_cnt_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         fault_cnt_p1 <= 8'd0;
      end else if (fault_p0) begin
         fault_cnt_p1 <= sat_inc8(fault_cnt_p1);
      end
   end

   assign fault_count = fault_cnt_p1;
`endif

   assign _WB             = wb_p1;
   assign _read_data      = rdata_p1;
   assign _ALU_result     = alu_p1;
   assign _RegDst_address = rd_addr_p1;
   assign mem_fault       = fault_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for the MEM/WB register path plus
// hand-written sequences for branch, reset and (when enabled) misalignment traps.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  WB;
   logic [2:0]  M;
   logic [7:0]  jump_address;
   logic [7:0]  ALU_status;
   logic [31:0] ALU_result;
   logic [31:0] write_data;
   logic [4:0]  RegDst_address;
   logic        PCSrc;
   logic [7:0]  branch_target;
   logic [1:0]  _WB;
   logic [31:0] _read_data;
   logic [31:0] _ALU_result;
   logic [4:0]  _RegDst_address;
   logic        mem_fault;
`ifdef MEM_MISALIGN_TRAP_EN
   logic [7:0]  fault_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   mem_stage #(.ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .WB(WB), .M(M), .jump_address(jump_address),
      .ALU_status(ALU_status), .ALU_result(ALU_result), .write_data(write_data),
      .RegDst_address(RegDst_address), .PCSrc(PCSrc), .branch_target(branch_target),
      ._WB(_WB), ._read_data(_read_data), ._ALU_result(_ALU_result),
      ._RegDst_address(_RegDst_address), .mem_fault(mem_fault)
`ifdef MEM_MISALIGN_TRAP_EN
      , .fault_count(fault_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  m;
      logic [1:0]  wb;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  rd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic [2:0] m, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [1:0] wb, input logic [4:0] rd);
      M = m; ALU_result = alu; write_data = wd; WB = wb; RegDst_address = rd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{3'b001, 2'b01, 32'h10,  32'hDEADBEEF, 5'd3,  32'h0};
      vecs[1]  = '{3'b010, 2'b11, 32'h10,  32'h0,        5'd4,  32'hDEADBEEF};
      vecs[2]  = '{3'b001, 2'b00, 32'h400, 32'h12345678, 5'd5,  32'h0};
      vecs[3]  = '{3'b010, 2'b10, 32'h000, 32'h0,        5'd6,  32'h12345678};
      vecs[4]  = '{3'b011, 2'b10, 32'h20,  32'hA5A5A5A5, 5'd7,  32'h0};
      vecs[5]  = '{3'b010, 2'b01, 32'h20,  32'h0,        5'd8,  32'hA5A5A5A5};
      vecs[6]  = '{3'b000, 2'b11, 32'h20,  32'h0,        5'd9,  32'h0};
      vecs[7]  = '{3'b010, 2'b11, 32'h44,  32'h0,        5'd10, 32'h0};
      vecs[8]  = '{3'b100, 2'b01, 32'h10,  32'h55555555, 5'd11, 32'h0};
      vecs[9]  = '{3'b001, 2'b00, 32'h3FC, 32'hCAFEF00D, 5'd12, 32'h0};
      vecs[10] = '{3'b010, 2'b11, 32'hFFC, 32'h0,        5'd31, 32'hCAFEF00D};

      rst = 1'b1; WB = 2'b11; M = 3'b000; jump_address = 8'h3C; ALU_status = 8'h01;
      ALU_result = 32'hFFFF_FFFF; write_data = 32'h0; RegDst_address = 5'd31;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_wb", {30'd0, _WB}, 32'd0);
      chk("rst_rd", _read_data, 32'd0);
      chk("rst_alu", _ALU_result, 32'd0);
      chk("rst_rdaddr", {27'd0, _RegDst_address}, 32'd0);
      chk("rst_fault", {31'd0, mem_fault}, 32'd0);
      M = 3'b100; #1;
      chk("rst_pcsrc_comb", {31'd0, PCSrc}, 32'd1);
      chk("rst_target_comb", {24'd0, branch_target}, 32'h3C);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         apply(vecs[i].m, vecs[i].alu, vecs[i].wd, vecs[i].wb, vecs[i].rd);
         chk($sformatf("v%0d_rd", i), _read_data, vecs[i].exp_rd);
         chk($sformatf("v%0d_wb", i), {30'd0, _WB}, {30'd0, vecs[i].wb});
         chk($sformatf("v%0d_alu", i), _ALU_result, vecs[i].alu);
         chk($sformatf("v%0d_rdaddr", i), {27'd0, _RegDst_address}, {27'd0, vecs[i].rd});
         chk($sformatf("v%0d_fault", i), {31'd0, mem_fault}, 32'd0);
      end

      // Branch resolution is purely combinational.
      M = 3'b100; ALU_status = 8'h01; jump_address = 8'h3C; #1;
      chk("br_taken", {31'd0, PCSrc}, 32'd1);
      chk("br_target", {24'd0, branch_target}, 32'h3C);
      ALU_status = 8'h00; #1;
      chk("br_not_zero", {31'd0, PCSrc}, 32'd0);
      M = 3'b000; ALU_status = 8'hFF; jump_address = 8'hA7; #1;
      chk("br_no_branch", {31'd0, PCSrc}, 32'd0);
      chk("br_target2", {24'd0, branch_target}, 32'hA7);
      M = 3'b100; ALU_status = 8'hFE; #1;
      chk("br_upper_flags", {31'd0, PCSrc}, 32'd0);
      @(negedge clk);

      // Reset mid-operation discards a concurrent store and clears memory.
      apply(3'b001, 32'h08, 32'h0BADF00D, 2'b11, 5'd2);
      M = 3'b001; ALU_result = 32'h08; write_data = 32'h11112222; WB = 2'b11; RegDst_address = 5'd9;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_wb", {30'd0, _WB}, 32'd0);
      chk("midrst_alu", _ALU_result, 32'd0);
      chk("midrst_rdaddr", {27'd0, _RegDst_address}, 32'd0);
      chk("midrst_rd", _read_data, 32'd0);
      apply(3'b010, 32'h08, 32'h0, 2'b01, 5'd1);
      chk("midrst_load08", _read_data, 32'd0);
      apply(3'b010, 32'h10, 32'h0, 2'b01, 5'd1);
      chk("midrst_load10", _read_data, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
      chk("trap_cnt0", {24'd0, fault_count}, 32'd0);
      apply(3'b001, 32'h20, 32'h00000055, 2'b11, 5'd3);
      apply(3'b001, 32'h22, 32'hBAD0BAD0, 2'b11, 5'd3);
      chk("trap_wb", {30'd0, _WB}, 32'd0);
      chk("trap_fault", {31'd0, mem_fault}, 32'd1);
      chk("trap_cnt1", {24'd0, fault_count}, 32'd1);
      chk("trap_alu", _ALU_result, 32'h22);
      apply(3'b010, 32'h20, 32'h0, 2'b11, 5'd3);
      chk("trap_fault_clr", {31'd0, mem_fault}, 32'd0);
      chk("trap_mem_kept", _read_data, 32'h00000055);
      chk("trap_wb_ok", {30'd0, _WB}, 32'd3);
      apply(3'b010, 32'h21, 32'h0, 2'b11, 5'd3);
      chk("trap_load_rd", _read_data, 32'd0);
      chk("trap_cnt2", {24'd0, fault_count}, 32'd2);
      for (int i = 0; i < 298; i++) begin
         apply(3'b010, 32'h23, 32'h0, 2'b01, 5'd3);
      end
      chk("trap_cnt_sat", {24'd0, fault_count}, 32'd255);
      apply(3'b001, 32'h43, 32'h1, 2'b01, 5'd3);
      chk("trap_cnt_hold", {24'd0, fault_count}, 32'd255);
`else
      apply(3'b001, 32'h22, 32'hBAD0BAD0, 2'b11, 5'd3);
      chk("align_wb", {30'd0, _WB}, 32'd3);
      chk("align_fault", {31'd0, mem_fault}, 32'd0);
      apply(3'b010, 32'h20, 32'h0, 2'b10, 5'd4);
      chk("align_load", _read_data, 32'hBAD0BAD0);
      apply(3'b010, 32'h23, 32'h0, 2'b10, 5'd4);
      chk("align_load_lo", _read_data, 32'hBAD0BAD0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
